// File: rtl/icmp_rx.sv
// Receive-side ICMP echo-request parser: validates type/code/length (and the
// checksum when ICMP_RX_CHECKSUM_EN is defined) and emits a reply trigger.
module icmp_rx #(
  parameter logic [7:0]  P_ICMP_TYPE_REQ = 8'd8,
  parameter logic [15:0] P_MIN_LEN       = 16'd8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_icmp_data,
  input  logic        i_icmp_valid,
  input  logic        i_icmp_last,
  output logic        o_trig_reply,
  output logic [15:0] o_trig_seq,
  output logic [15:0] o_trig_id,
  output logic        o_rx_err
);

  typedef enum logic [2:0] {IDLE, RECV, FOLD1, FOLD2, DECIDE, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  code_q, code_d;
  logic [15:0] id_cap_q, id_cap_d;
  logic [15:0] seq_cap_q, seq_cap_d;
  logic        ovl_q, ovl_d;
  logic        ovl_last_q, ovl_last_d;
  logic        reply_q, err_q;
  logic [15:0] seq_q, id_q;
  logic        accept_c, reject_c;
  logic        csum_ok;

  logic beat, overlap_beat, enter_idle, ovl_seen, ovl_closed;

  assign beat         = i_icmp_valid && ((state_q == IDLE) || (state_q == RECV));
  assign overlap_beat = i_icmp_valid &&
                        ((state_q == FOLD1) || (state_q == FOLD2) || (state_q == DECIDE));
  assign enter_idle   = (state_q != IDLE) && (state_d == IDLE);

  // A violating frame whose last beat already arrived during the decision
  // window needs no drain; otherwise discard through its last beat.
  assign ovl_seen   = ovl_q || overlap_beat;
  assign ovl_closed = overlap_beat ? i_icmp_last : ovl_last_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_icmp_valid) state_d = i_icmp_last ? FOLD1 : RECV;
      RECV:    if (i_icmp_valid && i_icmp_last) state_d = FOLD1;
      FOLD1:   state_d = FOLD2;
      FOLD2:   state_d = DECIDE;
      DECIDE:  state_d = (ovl_seen && !ovl_closed) ? DRAIN : IDLE;
      DRAIN:   if (i_icmp_valid && i_icmp_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept_c = 1'b0;
    reject_c = 1'b0;
    if (state_q == DECIDE && type_q == P_ICMP_TYPE_REQ && code_q == 8'd0) begin
      if (count_q >= P_MIN_LEN && csum_ok) accept_c = 1'b1;
      else                                 reject_c = 1'b1;
    end
  end

  always_comb begin
    count_d    = count_q;
    type_d     = type_q;
    code_d     = code_q;
    id_cap_d   = id_cap_q;
    seq_cap_d  = seq_cap_q;
    ovl_d      = ovl_q;
    ovl_last_d = ovl_last_q;
    if (enter_idle) begin
      count_d    = '0;
      type_d     = '0;
      code_d     = '0;
      ovl_d      = 1'b0;
      ovl_last_d = 1'b0;
    end else if (beat) begin
      count_d = (count_q == '1) ? count_q : count_q + 16'd1;
      case (count_q)
        16'd0:   type_d           = i_icmp_data;
        16'd1:   code_d           = i_icmp_data;
        16'd4:   id_cap_d[15:8]   = i_icmp_data;
        16'd5:   id_cap_d[7:0]    = i_icmp_data;
        16'd6:   seq_cap_d[15:8]  = i_icmp_data;
        16'd7:   seq_cap_d[7:0]   = i_icmp_data;
        default: ;
      endcase
    end else if (overlap_beat) begin
      ovl_d      = 1'b1;
      ovl_last_d = i_icmp_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q    <= '0;
      type_q     <= '0;
      code_q     <= '0;
      id_cap_q   <= '0;
      seq_cap_q  <= '0;
      ovl_q      <= 1'b0;
      ovl_last_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      type_q     <= type_d;
      code_q     <= code_d;
      id_cap_q   <= id_cap_d;
      seq_cap_q  <= seq_cap_d;
      ovl_q      <= ovl_d;
      ovl_last_q <= ovl_last_d;
    end
  end

`ifdef ICMP_RX_CHECKSUM_EN
  logic [31:0] acc_q, acc_d;
  logic [7:0]  hi_q, hi_d;

  always_comb begin
    acc_d = acc_q;
    hi_d  = hi_q;
    if (enter_idle) begin
      acc_d = '0;
    end else if (beat) begin
      if (!count_q[0]) begin
        hi_d = i_icmp_data;
        if (i_icmp_last) acc_d = acc_q + {16'h0000, i_icmp_data, 8'h00};
      end else begin
        acc_d = acc_q + {16'h0000, hi_q, i_icmp_data};
      end
    end else if (state_q == FOLD1 || state_q == FOLD2) begin
      acc_d = {16'h0000, acc_q[31:16]} + {16'h0000, acc_q[15:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q <= '0;
      hi_q  <= '0;
    end else begin
      acc_q <= acc_d;
      hi_q  <= hi_d;
    end
  end

  assign csum_ok = (acc_q[15:0] == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reply_q <= 1'b0;
      err_q   <= 1'b0;
      seq_q   <= '0;
      id_q    <= '0;
    end else begin
      reply_q <= accept_c;
      err_q   <= reject_c;
      if (accept_c) begin
        seq_q <= seq_cap_q;
        id_q  <= id_cap_q;
      end
    end
  end

  assign o_trig_reply = reply_q;
  assign o_rx_err     = err_q;
  assign o_trig_seq   = seq_q;
  assign o_trig_id    = id_q;

endmodule

// File: tb/tb_icmp_rx.sv
// Bench for icmp_rx: directed spec frames plus random frames scored against a
// frame-level reference model (ones-complement sum over the whole frame).
module tb_icmp_rx;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_icmp_data;
  logic        i_icmp_valid;
  logic        i_icmp_last;
  logic        o_trig_reply;
  logic [15:0] o_trig_seq;
  logic [15:0] o_trig_id;
  logic        o_rx_err;

  icmp_rx #(.P_ICMP_TYPE_REQ(8'd8), .P_MIN_LEN(16'd8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_icmp_data(i_icmp_data),
    .i_icmp_valid(i_icmp_valid), .i_icmp_last(i_icmp_last),
    .o_trig_reply(o_trig_reply), .o_trig_seq(o_trig_seq),
    .o_trig_id(o_trig_id), .o_rx_err(o_rx_err)
  );

  always #5 i_clk = ~i_clk;

`ifdef ICMP_RX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  int unsigned cyc = 0;
  int unsigned last_cyc = 0;
  int unsigned pulse_cyc = 0;
  int          rep_cnt = 0, err_cnt = 0;
  int          pass_cnt = 0, total_cnt = 0;
  logic [15:0] rep_seqs[$];
  logic [7:0]  fq[$];
  logic [15:0] exp_seq = 16'h0000, exp_id = 16'h0000;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_trig_reply) begin
      rep_cnt++;
      pulse_cyc = cyc;
      rep_seqs.push_back(o_trig_seq);
    end
    if (o_rx_err) begin
      err_cnt++;
      pulse_cyc = cyc;
    end
  end

  // Ones-complement 16-bit sum of the frame, odd tail padded with a zero byte.
  function automatic logic [15:0] csum_of();
    int unsigned s = 0;
    for (int i = 0; i < int'(fq.size()); i += 2) begin
      s += (int'(fq[i]) << 8) + ((i + 1 < int'(fq.size())) ? int'(fq[i+1]) : 0);
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    end
    return s[15:0];
  endfunction

  // 0 = silent drop, 1 = reply, 2 = error pulse
  function automatic int model_out();
    logic [7:0] typ, code;
    typ  = fq[0];
    code = (fq.size() > 1) ? fq[1] : 8'h00;
    if (typ != 8'd8 || code != 8'd0) return 0;
    if (fq.size() >= 8 && (!CSUM_EN || csum_of() == 16'hFFFF)) return 1;
    return 2;
  endfunction

  task automatic model_commit();
    if (model_out() == 1) begin
      exp_id  = {fq[4], fq[5]};
      exp_seq = {fq[6], fq[7]};
    end
  endtask

  task automatic build_req(input logic [7:0] typ, input logic [7:0] code,
                           input logic [15:0] id, input logic [15:0] seq,
                           input int len, input bit good);
    logic [15:0] c;
    fq.delete();
    fq.push_back(typ); fq.push_back(code); fq.push_back(8'h00); fq.push_back(8'h00);
    fq.push_back(id[15:8]); fq.push_back(id[7:0]);
    fq.push_back(seq[15:8]); fq.push_back(seq[7:0]);
    while (int'(fq.size()) < len) fq.push_back(8'($urandom));
    while (int'(fq.size()) > len) void'(fq.pop_back());
    c = ~csum_of();
    if (!good) c = c ^ 16'h0100;
    fq[2] = c[15:8];
    fq[3] = c[7:0];
  endtask

  task automatic build_spec(input logic [15:0] csum, input bit odd);
    fq.delete();
    fq.push_back(8'h08); fq.push_back(8'h00);
    fq.push_back(csum[15:8]); fq.push_back(csum[7:0]);
    fq.push_back(8'h00); fq.push_back(8'h01); fq.push_back(8'h12); fq.push_back(8'h34);
    repeat (32) fq.push_back(8'h00);
    if (odd) fq.push_back(8'hAB);
  endtask

  task automatic drive_frame(input int nbytes, input bit gaps);
    for (int i = 0; i < nbytes; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        i_icmp_valid = 1'b0; i_icmp_last = 1'b0; @(negedge i_clk);
      end
      i_icmp_valid = 1'b1;
      i_icmp_data  = fq[i];
      i_icmp_last  = (i == int'(fq.size()) - 1);
      @(negedge i_clk);
    end
    i_icmp_valid = 1'b0;
    i_icmp_last  = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic run_frame(input bit gaps, output int d_rep, output int d_err, output int lat);
    int r0, e0;
    r0 = rep_cnt; e0 = err_cnt; pulse_cyc = 0;
    drive_frame(int'(fq.size()), gaps);
    repeat (6) @(negedge i_clk);
    d_rep = rep_cnt - r0;
    d_err = err_cnt - e0;
    lat   = int'(pulse_cyc) - int'(last_cyc);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    total_cnt++; if (o_trig_reply !== 1'b0) $display("FAIL reset_reply: got %b want 0", o_trig_reply); else pass_cnt++;
    total_cnt++; if (o_rx_err !== 1'b0) $display("FAIL reset_err: got %b want 0", o_rx_err); else pass_cnt++;
    total_cnt++; if (o_trig_seq !== 16'h0000) $display("FAIL reset_seq: got %h want 0000", o_trig_seq); else pass_cnt++;
    total_cnt++; if (o_trig_id !== 16'h0000) $display("FAIL reset_id: got %h want 0000", o_trig_id); else pass_cnt++;
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_accept();
    int dr, de, lat;
    build_spec(16'hE5CA, 1'b0);
    model_commit();
    run_frame(1'b0, dr, de, lat);
    total_cnt++; if (dr !== 1) $display("FAIL accept_reply: got %0d want 1", dr); else pass_cnt++;
    total_cnt++; if (de !== 0) $display("FAIL accept_err: got %0d want 0", de); else pass_cnt++;
    total_cnt++; if (lat !== 3) $display("FAIL accept_latency: got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (o_trig_seq !== 16'h1234) $display("FAIL accept_seq: got %h want 1234", o_trig_seq); else pass_cnt++;
    total_cnt++; if (o_trig_id !== 16'h0001) $display("FAIL accept_id: got %h want 0001", o_trig_id); else pass_cnt++;
  endtask

  task automatic test_bad_csum();
    int dr, de, lat, want_r, want_e;
    build_spec(16'hE5CB, 1'b0);
    want_r = CSUM_EN ? 0 : 1;
    want_e = CSUM_EN ? 1 : 0;
    model_commit();
    run_frame(1'b0, dr, de, lat);
    total_cnt++; if (dr !== want_r) $display("FAIL badcsum_reply: got %0d want %0d", dr, want_r); else pass_cnt++;
    total_cnt++; if (de !== want_e) $display("FAIL badcsum_err: got %0d want %0d", de, want_e); else pass_cnt++;
    total_cnt++; if (o_trig_seq !== 16'h1234) $display("FAIL badcsum_seq: got %h want 1234", o_trig_seq); else pass_cnt++;
  endtask

  task automatic test_odd_gaps();
    int dr, de, lat;
    build_spec(16'h3ACA, 1'b1);
    model_commit();
    run_frame(1'b1, dr, de, lat);
    total_cnt++; if (dr !== 1) $display("FAIL odd_reply: got %0d want 1", dr); else pass_cnt++;
    total_cnt++; if (lat !== 3) $display("FAIL odd_latency: got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (o_trig_seq !== 16'h1234) $display("FAIL odd_seq: got %h want 1234", o_trig_seq); else pass_cnt++;
  endtask

  task automatic test_non_request();
    int dr, de, lat;
    build_req(8'd0, 8'd0, 16'h7777, 16'h8888, 24, 1'b1);
    run_frame(1'b0, dr, de, lat);
    total_cnt++; if (dr !== 0) $display("FAIL type0_reply: got %0d want 0", dr); else pass_cnt++;
    total_cnt++; if (de !== 0) $display("FAIL type0_err: got %0d want 0", de); else pass_cnt++;
    build_req(8'd8, 8'd0, 16'h7777, 16'h8888, 6, 1'b1);
    run_frame(1'b0, dr, de, lat);
    total_cnt++; if (dr !== 0) $display("FAIL short_reply: got %0d want 0", dr); else pass_cnt++;
    total_cnt++; if (de !== 1) $display("FAIL short_err: got %0d want 1", de); else pass_cnt++;
    total_cnt++; if (o_trig_seq !== exp_seq) $display("FAIL short_seq: got %h want %h", o_trig_seq, exp_seq); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int r0, e0;
    r0 = rep_cnt; e0 = err_cnt;
    rep_seqs.delete();
    build_req(8'd8, 8'd0, 16'h0A0A, 16'h1111, 20, 1'b1);
    drive_frame(int'(fq.size()), 1'b0);
    @(negedge i_clk);
    build_req(8'd8, 8'd0, 16'h0B0B, 16'h2222, 20, 1'b1);
    drive_frame(int'(fq.size()), 1'b0);
    repeat (3) @(negedge i_clk);
    build_req(8'd8, 8'd0, 16'h0C0C, 16'h3333, 20, 1'b1);
    model_commit();
    drive_frame(int'(fq.size()), 1'b0);
    repeat (6) @(negedge i_clk);
    total_cnt++; if (rep_cnt - r0 !== 2) $display("FAIL overlap_replies: got %0d want 2", rep_cnt - r0); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL overlap_errs: got %0d want 0", err_cnt - e0); else pass_cnt++;
    if (rep_seqs.size() == 2) begin
      total_cnt++; if (rep_seqs[0] !== 16'h1111) $display("FAIL overlap_first_seq: got %h want 1111", rep_seqs[0]); else pass_cnt++;
      total_cnt++; if (rep_seqs[1] !== 16'h3333) $display("FAIL overlap_third_seq: got %h want 3333", rep_seqs[1]); else pass_cnt++;
    end
    total_cnt++; if (o_trig_id !== 16'h0C0C) $display("FAIL overlap_id: got %h want 0c0c", o_trig_id); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int r0, e0, dr, de, lat;
    r0 = rep_cnt; e0 = err_cnt;
    build_req(8'd8, 8'd0, 16'hCAFE, 16'hBEEF, 40, 1'b1);
    drive_frame(20, 1'b0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_seq = 16'h0000; exp_id = 16'h0000;
    repeat (8) @(negedge i_clk);
    total_cnt++; if (rep_cnt - r0 + err_cnt - e0 !== 0) $display("FAIL midrst_pulses: got %0d want 0", rep_cnt - r0 + err_cnt - e0); else pass_cnt++;
    total_cnt++; if (o_trig_seq !== 16'h0000) $display("FAIL midrst_seq: got %h want 0000", o_trig_seq); else pass_cnt++;
    total_cnt++; if (o_trig_id !== 16'h0000) $display("FAIL midrst_id: got %h want 0000", o_trig_id); else pass_cnt++;
    build_req(8'd8, 8'd0, 16'hCAFE, 16'hBEEF, 40, 1'b1);
    model_commit();
    run_frame(1'b0, dr, de, lat);
    total_cnt++; if (dr !== 1) $display("FAIL midrst_next_reply: got %0d want 1", dr); else pass_cnt++;
    total_cnt++; if (o_trig_seq !== 16'hBEEF) $display("FAIL midrst_next_seq: got %h want beef", o_trig_seq); else pass_cnt++;
  endtask

  task automatic test_random();
    int dr, de, lat, want;
    for (int n = 0; n < 30; n++) begin
      build_req(($urandom_range(0, 3) == 0) ? 8'd0 : 8'd8,
                ($urandom_range(0, 5) == 0) ? 8'd1 : 8'd0,
                16'($urandom), 16'($urandom), $urandom_range(6, 48),
                $urandom_range(0, 2) != 0);
      want = model_out();
      model_commit();
      run_frame(1'b1, dr, de, lat);
      total_cnt++; if (dr !== (want == 1 ? 1 : 0)) $display("FAIL rand%0d_reply: got %0d want %0d", n, dr, want == 1); else pass_cnt++;
      total_cnt++; if (de !== (want == 2 ? 1 : 0)) $display("FAIL rand%0d_err: got %0d want %0d", n, de, want == 2); else pass_cnt++;
      total_cnt++; if (o_trig_seq !== exp_seq) $display("FAIL rand%0d_seq: got %h want %h", n, o_trig_seq, exp_seq); else pass_cnt++;
      total_cnt++; if (o_trig_id !== exp_id) $display("FAIL rand%0d_id: got %h want %h", n, o_trig_id, exp_id); else pass_cnt++;
      if (want != 0) begin
        total_cnt++; if (lat !== 3) $display("FAIL rand%0d_latency: got %0d want 3", n, lat); else pass_cnt++;
      end
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_icmp_data = 8'h00;
    i_icmp_valid = 1'b0;
    i_icmp_last = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_accept();
    test_bad_csum();
    test_odd_gaps();
    test_non_request();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
